// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample/slot widths, frame length and the stereo pair type.
// Used by i2s_tx (optional underrun counter enabled by macro I2S_TX_UNDERRUN_CNT_EN).
package i2s_pkg;

  localparam int DATA_W_DEF    = 24;
  localparam int SLOT_W_DEF    = 32;
  localparam int FRAME_LEN_DEF = 2 * SLOT_W_DEF;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] left;
    logic [DATA_W_DEF-1:0] right;
  } pair_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Two-entry FIFO holding stereo pairs waiting for the next I2S frame load.
// Pushes are ignored when full and pops are ignored when empty.
module i2s_tx_fifo #(
  parameter int W = 48
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wrPtr_q, rdPtr_q;
  logic [1:0]   count_q, count_d;
  logic         pushOk, popOk;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign data_o  = mem_q[rdPtr_q];
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;

  // Simultaneous push and pop keeps the occupancy but still advances both pointers.
  always_comb begin
    count_d = count_q;
    if (pushOk && !popOk) begin
      count_d = count_q + 2'd1;
    end else if (popOk && !pushOk) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (popOk) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: frame counter, registered lrck/din with one-bit delay, 2-pair input buffer.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_cnt output.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              bck,
  input  logic              rst,
  input  logic [DATA_W-1:0] l_din,
  input  logic [DATA_W-1:0] r_din,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              lrck,
  output logic              din,
  output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
 ,output logic [15:0]       underrun_cnt
`endif
);

  localparam int FRAME_LEN = 2 * SLOT_W;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] L_FIRST  = CW'(1);
  localparam logic [CW-1:0] L_LAST   = CW'(DATA_W);
  localparam logic [CW-1:0] R_START  = CW'(SLOT_W);
  localparam logic [CW-1:0] R_FIRST  = CW'(SLOT_W + 1);
  localparam logic [CW-1:0] R_LAST   = CW'(SLOT_W + DATA_W);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   lsh_q, lsh_d, rsh_q, rsh_d;
  logic                lrck_q, lrck_d, din_q, din_d;
  logic                active_q;
  logic                frameLoad, fifoFull, fifoEmpty;
  logic [2*DATA_W-1:0] fifoHead;

  i2s_tx_fifo #(.W(2 * DATA_W)) u_fifo (
    .clk_i   (bck),
    .rst_i   (rst),
    .push_i  (in_valid && in_ready),
    .data_i  ({l_din, r_din}),
    .pop_i   (frameLoad),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign frameLoad = (cnt_q == CNT_LAST);
  assign underrun  = frameLoad && fifoEmpty;
  assign in_ready  = active_q && !fifoFull;
  assign lrck      = lrck_q;
  assign din       = din_q;

  // Outputs are computed for the next count so the registered din/lrck line up with cnt_q.
  always_comb begin
    cnt_d  = frameLoad ? '0 : cnt_q + 1'b1;
    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    din_d  = 1'b0;
    lrck_d = (cnt_d >= R_START);
    if (frameLoad) begin
      lsh_d = fifoEmpty ? '0 : fifoHead[2*DATA_W-1:DATA_W];
      rsh_d = fifoEmpty ? '0 : fifoHead[DATA_W-1:0];
    end else if (cnt_d >= L_FIRST && cnt_d <= L_LAST) begin
      din_d = lsh_q[DATA_W-1];
      lsh_d = {lsh_q[DATA_W-2:0], 1'b0};
    end else if (cnt_d >= R_FIRST && cnt_d <= R_LAST) begin
      din_d = rsh_q[DATA_W-1];
      rsh_d = {rsh_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge bck or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      lsh_q    <= '0;
      rsh_q    <= '0;
      lrck_q   <= 1'b0;
      din_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lsh_q    <= lsh_d;
      rsh_q    <= rsh_d;
      lrck_q   <= lrck_d;
      din_q    <= din_d;
      active_q <= 1'b1;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && ucnt_q != 16'hFFFF) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge bck or posedge rst) begin
    if (rst) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: directed and random pairs checked cycle by cycle against a frame-level model.
// Honours I2S_TX_UNDERRUN_CNT_EN when the design is built with the underrun counter.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int SW = SLOT_W_DEF;
  localparam int FL = 2 * SW;

  logic          bck = 1'b0;
  logic          rst;
  logic [DW-1:0] l_din, r_din;
  logic          in_valid;
  logic          in_ready, lrck, din, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  i2s_tx #(.DATA_W(DW), .SLOT_W(SW)) dut (
    .bck          (bck),
    .rst          (rst),
    .l_din        (l_din),
    .r_din        (r_din),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .lrck         (lrck),
    .din          (din),
    .underrun     (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,.underrun_cnt (underrun_cnt)
`endif
  );

  always #5 bck = ~bck;

  int testCount = 0;
  int failCount = 0;

  // Frame-level model: position in frame, buffered pairs, pair on the wire, ready flag.
  int    mPos;
  pair_t mQ[$];
  pair_t mCur;
  logic  mReady;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] mUcnt;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expBit(input pair_t p, input int pos);
    if (pos >= 1 && pos <= DW) return p.left[DW - pos];
    if (pos >= SW + 1 && pos <= SW + DW) return p.right[SW + DW - pos];
    return 1'b0;
  endfunction

  task automatic resetModel();
    mPos   = 0;
    mQ.delete();
    mCur   = '0;
    mReady = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    mUcnt  = 16'd0;
`endif
  endtask

  // Checks the current outputs, drives one cycle of inputs and advances the model across the edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                               output logic accepted);
    string t;
    t = $sformatf("pos%0d", mPos);
    checkOutput({t, " lrck"}, 32'(lrck), 32'(mPos >= SW));
    checkOutput({t, " din"}, 32'(din), 32'(expBit(mCur, mPos)));
    checkOutput({t, " underrun"}, 32'(underrun), 32'(mPos == FL - 1 && mQ.size() == 0));
    checkOutput({t, " in_ready"}, 32'(in_ready), 32'(mReady));
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checkOutput({t, " underrun_cnt"}, 32'(underrun_cnt), 32'(mUcnt));
`endif
    in_valid = v;
    l_din    = l;
    r_din    = r;
    accepted = v && mReady;
    if (mPos == FL - 1) begin
      if (mQ.size() > 0) begin
        mCur = mQ.pop_front();
      end else begin
        mCur = '0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        if (mUcnt != 16'hFFFF) mUcnt = mUcnt + 16'd1;
`endif
      end
    end
    if (accepted) mQ.push_back(pair_t'{left: l, right: r});
    mReady = (mQ.size() < 2);
    mPos   = (mPos + 1) % FL;
    @(posedge bck);
    @(negedge bck);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, acc);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          acc;
    int            idx;
    int            budget;
    logic [DW-1:0] cL[3];
    logic [DW-1:0] cR[3];

    rst      = 1'b1;
    in_valid = 1'b0;
    l_din    = '0;
    r_din    = '0;
    resetModel();
    repeat (3) @(negedge bck);
    checkOutput("reset lrck", 32'(lrck), 32'd0);
    checkOutput("reset din", 32'(din), 32'd0);
    checkOutput("reset underrun", 32'(underrun), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // Starved transmitter: silent frames with an underrun at the end of each.
    idle(3 * FL);

    // Known patterns, including the loopback pair, pushed before the wrap.
    applyStimulus(1'b1, 24'h5A5A5A, 24'hA5A5A5, acc);
    checkOutput("push 5A5A5A accepted", 32'(acc), 32'd1);
    applyStimulus(1'b1, 24'h200000, 24'hE00000, acc);
    checkOutput("push 200000 accepted", 32'(acc), 32'd1);
    idle(3 * FL);

    // Hold valid across three distinct pairs; the third must wait for a pop.
    cL[0] = 24'h111111; cR[0] = 24'h999999;
    cL[1] = 24'h222222; cR[1] = 24'hAAAAAA;
    cL[2] = 24'h333333; cR[2] = 24'hBBBBBB;
    idx    = 0;
    budget = 0;
    while (idx < 3 && budget < 4 * FL) begin
      applyStimulus(1'b1, cL[idx], cR[idx], acc);
      if (acc) idx++;
      budget++;
    end
    checkOutput("held valid accepts", 32'(idx), 32'd3);
    idle(4 * FL);

    // Random data at varying offered rates, so both backpressure and underruns occur.
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < FL; c++) begin
        applyStimulus(($urandom_range(0, 15) < f * 2) ? 1'b1 : 1'b0,
                      DW'($urandom), DW'($urandom), acc);
      end
    end
    idle(3 * FL);

    // Reset mid-frame with a full buffer.
    while (mPos != 1) idle(1);
    budget = 0;
    while (mQ.size() < 2 && budget < 8) begin
      applyStimulus(1'b1, DW'($urandom), DW'($urandom), acc);
      budget++;
    end
    checkOutput("buffer full before reset", 32'(mQ.size()), 32'd2);
    while (mPos != 40) idle(1);
    checkOutput("lrck high at pos40", 32'(lrck), 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset lrck", 32'(lrck), 32'd0);
    checkOutput("async reset din", 32'(din), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("async reset underrun", 32'(underrun), 32'd0);
    resetModel();
    repeat (2) @(negedge bck);
    rst = 1'b0;
    idle(2 * FL);
    applyStimulus(1'b1, 24'h800001, 24'h7FFFFE, acc);
    idle(2 * FL);

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Counter near its ceiling must saturate rather than wrap.
    force dut.ucnt_q = 16'hFFFE;
    #1 release dut.ucnt_q;
    mUcnt = 16'hFFFE;
    @(negedge bck);
    idle(3 * FL);
    checkOutput("underrun_cnt saturated", 32'(underrun_cnt), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 24: sample width in bits.
REQ-002 SHALL have parameter SLOT_W, default 32: bck periods per channel slot; legal when SLOT_W >= DATA_W+1.
REQ-003 SHALL have port bck, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port l_din, input, DATA_W: left sample, two's complement.
REQ-006 SHALL have port r_din, input, DATA_W: right sample, two's complement.
REQ-007 SHALL have port in_valid, input, 1: l_din/r_din pair offered.
REQ-008 SHALL have port in_ready, output, 1: buffer can accept a pair.
REQ-009 SHALL have port lrck, output, 1: word select; 0 = left slot, 1 = right slot.
REQ-010 SHALL have port din, output, 1: serial data toward i2s_rx.
REQ-011 SHALL have port underrun, output, 1: one-cycle pulse on a frame load with an empty buffer.

Function
REQ-012 SHALL run a frame counter cnt from 0 to 2*SLOT_W-1, then wrap to 0.
REQ-013 SHALL drive lrck registered: 0 for cnt 0..SLOT_W-1 and 1 for cnt SLOT_W..2*SLOT_W-1.
REQ-014 SHALL use I2S one-bit delay: left MSB on din at cnt 1, left LSB at cnt DATA_W; right MSB at cnt SLOT_W+1, right LSB at cnt SLOT_W+DATA_W.
REQ-015 SHALL drive din 0 in every other slot position, including cnt 0 and cnt SLOT_W.
REQ-016 SHALL register din and lrck; both change only on rising bck, and a downstream stage samples them on the following rising edge.
REQ-017 SHALL buffer pairs in a 2-entry FIFO; a pair is accepted in a cycle where in_valid and in_ready are both 1.
REQ-018 SHALL drive in_ready as !full, registered; no push occurs when full, even in a cycle where a pop occurs.
REQ-019 SHALL pop one pair into the output shift register at cnt == 2*SLOT_W-1, so it transmits in the next frame.
REQ-020 SHALL, if the FIFO is empty at cnt == 2*SLOT_W-1, load {0,0}, assert underrun for that cycle, and keep the counter running.
REQ-021 SHALL, on a simultaneous push and pop with the FIFO non-empty and not full, leave the occupancy unchanged and preserve order.
REQ-022 SHALL emit a first frame after reset that is all-zero data, since its shift register holds the reset value.

Reset
REQ-023 SHALL, while rst=1, hold cnt=0, lrck=0, din=0, underrun=0, FIFO empty, shift register zero.
REQ-024 SHALL force in_ready=0 during reset and 1 from the first rising bck after rst falls.
REQ-025 SHALL, on reset asserted mid-frame, clear everything immediately; partially sent and buffered pairs are discarded.

Configuration
REQ-026 SHALL, with macro I2S_TX_UNDERRUN_CNT_EN defined, add output underrun_cnt (16 bits) that increments on each underrun, saturates at 16'hFFFF, and resets to 0.
REQ-027 SHALL, without I2S_TX_UNDERRUN_CNT_EN, omit the underrun_cnt port and counter; the underrun pulse remains.

Structure
REQ-028 SHALL take DATA_W, SLOT_W and the frame length 2*SLOT_W defaults from shared package i2s_pkg, which also holds the stereo pair struct {left, right}.
REQ-029 SHALL place the FIFO in sub-module i2s_tx_fifo (depth 2, push/pop, full/empty); the counter, shifter and underrun logic stay in i2s_tx.

Verification
REQ-030 SHALL cover: push L=24'h5A5A5A, R=24'hA5A5A5 before the first wrap -> frame 2 has din bits 1..24 = 5A5A5A MSB-first with lrck=0, and bits 33..56 = A5A5A5 with lrck=1.
REQ-031 SHALL cover: no pushes after reset -> din stays 0, underrun pulses once per 64 cycles at cnt 63, and underrun_cnt counts 1, 2, 3 when the macro is defined.
REQ-032 SHALL cover: hold in_valid=1 with 3 distinct pairs -> in_ready drops after 2 accepts, and pairs are emitted in order with none lost or duplicated.
REQ-033 SHALL cover: loopback into i2s_rx with L=24'h200000, R=24'hE00000 -> l_dout=24'h200000 and r_dout=24'hE00000 after the frame.
REQ-034 SHALL cover: rst pulse at cnt 40 with a full FIFO -> outputs return to reset values asynchronously, then output resumes at cnt 0 with a zero first frame.
REQ-035 SHALL cover: force the underrun counter to 16'hFFFE, then 3 underruns -> underrun_cnt holds at 16'hFFFF.
